jtag_mem_sequencer: RTL and testbench
=====================================

Name: jtag_mem_sequencer

Overview:
Core-clock controller that turns host commands from the virtual-JTAG register bank into single-word memory transactions on the SDRAM/RAM request port.
- Consumes the JTAG address, data and flags words and resynchronises the command toggles from the TCK domain.
- Sequences writes and reads with optional address auto-increment, and returns read data and status words to the JTAG capture inputs.
- Sits between the JTAG top block and the memory arbiter.

Parameters:
- DR_LEN, 32: width of the JTAG data, address and flags words (matches `DR_LENGTH).
- ADDR_INC, 4: byte increment applied to an address pointer after each auto-incremented access.
- SYNC_STAGES, 2: flip-flop depth of the toggle synchronisers; legal values 2 to 4.

Ports:
- clk  in  1: core clock; the block's only clock.
- reset  in  1: synchronous, active-high reset.
- jtag_flags  in  DR_LEN: flags word from the TCK domain, quasi-static. Bit 0 = write toggle, bit 1 = read toggle, bit 2 = auto-increment enable, bit 3 = clear error.
- jtag_raddr  in  DR_LEN: read address from the TCK domain, quasi-static.
- jtag_waddr  in  DR_LEN: write address from the TCK domain, quasi-static.
- jtag_wdata  in  DR_LEN: write data from the TCK domain, quasi-static.
- mem_req  out  1: memory request; held high until acknowledged.
- mem_we  out  1: 1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  DR_LEN: byte address; valid while mem_req is high.
- mem_wdata  out  DR_LEN: write data; valid while mem_req is high.
- mem_ack  in  1: one-cycle acknowledge. For a read, mem_rdata is valid in the same cycle.
- mem_rdata  in  DR_LEN: read data.
- rdata_out  out  DR_LEN: last read word, held; drives the JTAG rdata capture input.
- status_out  out  DR_LEN: {wr_count[7:0], rd_count[7:0], 13'b0, error, rd_pending|wr_pending, busy}.
- busy  out  1: high while the state machine is not IDLE.

Behaviour:
- Reset values:
  - all outputs 0; state = IDLE;
  - counts 0; error 0; pending flags 0;
  - synchroniser chains 0; last-seen toggle registers 0.
- Synchronisation:
  - jtag_flags[1:0] each pass through SYNC_STAGES flops.
  - A command is detected when a synchronised toggle differs from its last-seen value. Detection sets wr_pending or rd_pending and updates last-seen.
  - Address and data buses are sampled only when a command is issued. The host guarantees they are stable before it flips a toggle.
- Address pointers:
  - Separate wptr and rptr registers.
  - A pointer reloads from jtag_waddr or jtag_raddr when that bus differs from its shadow copy, captured at the previous issue.
  - Otherwise, if jtag_flags[2] is set, the pointer is used as already advanced.
  - After each completed access with auto-increment enabled, the pointer advances by ADDR_INC, modulo 2^DR_LEN.
- State machine (states IDLE, WR, RD):
  - IDLE: if wr_pending, go to WR and assert mem_req, mem_we=1, mem_addr=wptr, mem_wdata=jtag_wdata. Otherwise if rd_pending, go to RD with mem_we=0. If both are pending, the write is issued first.
  - WR: hold request outputs stable until mem_ack. On mem_ack: drop mem_req the next cycle, clear wr_pending, increment wr_count (wraps at 255), return to IDLE.
  - RD: on mem_ack, capture mem_rdata into rdata_out, clear rd_pending, increment rd_count (wraps), return to IDLE.
- Latency:
  - A toggle edge at clk input reaches mem_req after SYNC_STAGES+2 cycles, with the block idle.
  - The minimum back-to-back spacing between requests is one idle cycle.
- Overrun:
  - A toggle edge arriving while the same-type pending flag is already set sets error. The command is dropped and only one access is performed.
  - A toggle edge arriving in the same cycle its pending flag clears is not an overrun; it re-arms the pending flag.
- error is sticky until a synchronised jtag_flags[3] is seen high, or reset.
- A mem_ack seen in IDLE is ignored.
- Reset during WR or RD drops mem_req in the next cycle. Pending commands are lost, and last-seen registers are zeroed, so a host toggle already at 1 re-triggers after reset.

Optional Feature:
JTAG_SEQ_TIMEOUT_EN
- With the macro: a 16-bit counter runs while in WR or RD.
  - If it reaches 0xFFFF without mem_ack, the request is abandoned: mem_req goes low, error is set, the pending flag clears, and the state returns to IDLE.
  - For an abandoned read, rdata_out is loaded with 32'hDEADBEEF.
  - The counter clears on entry to WR or RD.
- Without the macro: the block waits indefinitely for mem_ack and the counter logic is absent.

Decomposition:
- Shared package/defines: DR_LENGTH; flag bit indices (FLAG_WR_TOG=0, FLAG_RD_TOG=1, FLAG_AUTOINC=2, FLAG_CLR_ERR=3); state encoding; status field offsets; timeout-read pattern.
- One natural sub-module, jtag_toggle_sync. It contains the parameterised flop chain plus edge detect and outputs a one-cycle pulse. It is instantiated once per toggle.

Test Plan:
- Single write: waddr=0x100, wdata=0xA5A5_0001, flip bit 0 → one mem_req with we=1, addr=0x100, data=0xA5A5_0001; wr_count=1; busy low after ack.
- Auto-increment read burst: raddr=0x200, autoinc=1, four read toggles, ack returns 0x11..0x44 → addresses 0x200, 0x204, 0x208, 0x20C; rdata_out=0x44; rd_count=4.
- Simultaneous commands: write and read toggles flipped together → write issued first, then read after one idle cycle.
- Overrun: two write toggles while mem_ack is held off → single write, error=1; flag bit 3 pulsed → error=0.
- Reset during RD with ack pending: assert reset for 1 cycle → mem_req=0 next cycle, counts 0, no rdata_out update from a late ack.
- (TIMEOUT_EN) Read with no ack → after 65535 cycles mem_req drops, error=1, rdata_out=0xDEADBEEF.

Source files
------------

// File: rtl/jtag_mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_mem_sequencer_pkg
// Description : Shared constants, flag bit indices, state encoding and
//               status-word field offsets for the JTAG memory sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_mem_sequencer_pkg;

  // Width of the JTAG data/address/flags registers
  localparam int DR_LENGTH = 32;

  // Bit positions inside the JTAG flags word
  localparam int FLAG_WR_TOG  = 0;
  localparam int FLAG_RD_TOG  = 1;
  localparam int FLAG_AUTOINC = 2;
  localparam int FLAG_CLR_ERR = 3;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10
  } state_t;

  // Field offsets inside the status word
  localparam int STAT_BUSY     = 0;
  localparam int STAT_PENDING  = 1;
  localparam int STAT_ERROR    = 2;
  localparam int STAT_RD_COUNT = 16;
  localparam int STAT_WR_COUNT = 24;

  // Word loaded into rdata_out when a read is abandoned on timeout
  localparam logic [31:0] TIMEOUT_RD_PATTERN = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/jtag_toggle_sync.sv
`default_nettype none
// ============================================================================
// Module      : jtag_toggle_sync
// Description : Resynchronises a TCK-domain command toggle into the core
//               clock domain and emits a one-cycle pulse per toggle edge.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tog,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   last_seen;

  // Shift the toggle through the flop chain and remember the last settled value
  always_ff @(posedge clk) begin
    if (reset) begin
      chain     <= '0;
      last_seen <= 1'b0;
    end else begin
      chain     <= {chain[SYNC_STAGES-2:0], tog};
      last_seen <= chain[SYNC_STAGES-1];
    end
  end

  // Any difference between the settled value and the last-seen copy is a new command
  assign pulse = chain[SYNC_STAGES-1] ^ last_seen;

endmodule
`default_nettype wire

// File: rtl/jtag_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jtag_mem_sequencer
// Description : Turns JTAG host commands (toggles in the flags word) into
//               single-word memory requests, with optional address
//               auto-increment, and reports read data and status back.
//               Optional macro JTAG_SEQ_TIMEOUT_EN adds a 16-bit request
//               timeout that abandons an unacknowledged access.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_mem_sequencer
  import jtag_mem_sequencer_pkg::*;
#(
  parameter int DR_LEN      = DR_LENGTH,
  parameter int ADDR_INC    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DR_LEN-1:0] jtag_flags,
  input  logic [DR_LEN-1:0] jtag_raddr,
  input  logic [DR_LEN-1:0] jtag_waddr,
  input  logic [DR_LEN-1:0] jtag_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DR_LEN-1:0] mem_addr,
  output logic [DR_LEN-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DR_LEN-1:0] mem_rdata,
  output logic [DR_LEN-1:0] rdata_out,
  output logic [DR_LEN-1:0] status_out,
  output logic              busy
);

  state_t            state, next_state;
  logic              wr_pulse, rd_pulse;
  logic              wr_pending, rd_pending, error;
  logic [7:0]        wr_count, rd_count;
  logic [DR_LEN-1:0] wptr, rptr, wshadow, rshadow;
  logic [DR_LEN-1:0] wr_addr_sel, rd_addr_sel;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic              autoinc, abandon;
  logic              wr_issue, rd_issue, wr_done, rd_done, wr_clear, rd_clear;
  logic              overrun;
  logic              unused_flags;

  assign unused_flags = ^jtag_flags[DR_LEN-1:4];

  jtag_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk   (clk),
    .reset (reset),
    .tog   (jtag_flags[FLAG_WR_TOG]),
    .pulse (wr_pulse)
  );

  jtag_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .tog   (jtag_flags[FLAG_RD_TOG]),
    .pulse (rd_pulse)
  );

  // Level synchroniser for the clear-error flag
  always_ff @(posedge clk) begin
    if (reset) clr_sync <= '0;
    else       clr_sync <= {clr_sync[SYNC_STAGES-2:0], jtag_flags[FLAG_CLR_ERR]};
  end

  assign autoinc  = jtag_flags[FLAG_AUTOINC];
  assign wr_issue = (state == ST_IDLE) && wr_pending;
  assign rd_issue = (state == ST_IDLE) && !wr_pending && rd_pending;
  assign wr_done  = (state == ST_WR) && mem_ack;
  assign rd_done  = (state == ST_RD) && mem_ack;
  assign wr_clear = (state == ST_WR) && (mem_ack || abandon);
  assign rd_clear = (state == ST_RD) && (mem_ack || abandon);
  assign overrun  = (wr_pulse && wr_pending && !wr_clear) ||
                    (rd_pulse && rd_pending && !rd_clear);

  // A changed bus (or no auto-increment) reloads the pointer; otherwise keep walking
  assign wr_addr_sel = ((jtag_waddr != wshadow) || !autoinc) ? jtag_waddr : wptr;
  assign rd_addr_sel = ((jtag_raddr != rshadow) || !autoinc) ? jtag_raddr : rptr;

`ifdef JTAG_SEQ_TIMEOUT_EN
  logic [15:0] timer;

  // Count cycles spent waiting for an acknowledge; cleared whenever idle
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) timer <= '0;
    else                           timer <= timer + 16'd1;
  end

  assign abandon = (state != ST_IDLE) && (timer == 16'hFFFF) && !mem_ack;
`else
  assign abandon = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: writes win over reads when both are pending
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (wr_pending)      next_state = ST_WR;
        else if (rd_pending) next_state = ST_RD;
      end
      ST_WR, ST_RD: begin
        if (mem_ack || abandon) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign mem_req = (state != ST_IDLE);
  assign mem_we  = (state == ST_WR);
  assign busy    = (state != ST_IDLE);

  // Capture request address/data at issue and advance pointers on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wptr      <= '0;
      rptr      <= '0;
      wshadow   <= '0;
      rshadow   <= '0;
    end else begin
      if (wr_issue) begin
        mem_addr  <= wr_addr_sel;
        mem_wdata <= jtag_wdata;
        wptr      <= wr_addr_sel;
        wshadow   <= jtag_waddr;
      end else if (rd_issue) begin
        mem_addr  <= rd_addr_sel;
        rptr      <= rd_addr_sel;
        rshadow   <= jtag_raddr;
      end
      if (wr_done && autoinc) wptr <= wptr + DR_LEN'(ADDR_INC);
      if (rd_done && autoinc) rptr <= rptr + DR_LEN'(ADDR_INC);
    end
  end

  // Pending flags, sticky error, counters and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pending <= 1'b0;
      rd_pending <= 1'b0;
      error      <= 1'b0;
      wr_count   <= '0;
      rd_count   <= '0;
      rdata_out  <= '0;
    end else begin
      if (wr_pulse)      wr_pending <= 1'b1;
      else if (wr_clear) wr_pending <= 1'b0;
      if (rd_pulse)      rd_pending <= 1'b1;
      else if (rd_clear) rd_pending <= 1'b0;

      if (overrun || abandon)          error <= 1'b1;
      else if (clr_sync[SYNC_STAGES-1]) error <= 1'b0;

      if (wr_done) wr_count <= wr_count + 8'd1;
      if (rd_done) begin
        rd_count  <= rd_count + 8'd1;
        rdata_out <= mem_rdata;
      end else if ((state == ST_RD) && abandon) begin
        rdata_out <= DR_LEN'(TIMEOUT_RD_PATTERN);
      end
    end
  end

  // Assemble the status word
  always_comb begin
    status_out                        = '0;
    status_out[STAT_BUSY]             = busy;
    status_out[STAT_PENDING]          = wr_pending | rd_pending;
    status_out[STAT_ERROR]            = error;
    status_out[STAT_RD_COUNT +: 8]    = rd_count;
    status_out[STAT_WR_COUNT +: 8]    = wr_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_mem_sequencer
// Description : Scoreboard bench for jtag_mem_sequencer. Host commands push
//               expected memory requests; a monitor pops and compares them
//               whenever the memory side acknowledges a request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_mem_sequencer;

  localparam int SS = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk, reset;
  logic [31:0] jtag_flags, jtag_raddr, jtag_waddr, jtag_wdata;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata_out, status_out;

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  logic [31:0] forced_q[$];
  logic [31:0] s_mem [logic [31:0]];
  logic [31:0] m_mem [logic [31:0]];
  logic        hold_ack = 1'b0;
  logic        late_ack = 1'b0;

  // Reference model state (host-visible behaviour only)
  logic [31:0] m_wbus, m_rbus, m_wnext, m_rnext, m_last_rd;
  logic [7:0]  m_wr_cnt, m_rd_cnt;

  jtag_mem_sequencer #(.DR_LEN(32), .ADDR_INC(4), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .jtag_flags (jtag_flags),
    .jtag_raddr (jtag_raddr),
    .jtag_waddr (jtag_waddr),
    .jtag_wdata (jtag_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rdata_out  (rdata_out),
    .status_out (status_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    m_wbus = '0; m_rbus = '0; m_wnext = '0; m_rnext = '0;
    m_last_rd = '0; m_wr_cnt = '0; m_rd_cnt = '0;
  endtask

  // New bus value (or no auto-increment) restarts at the bus; otherwise continue the walk
  task automatic expect_write();
    logic [31:0] a;
    a = (jtag_waddr != m_wbus || !jtag_flags[2]) ? jtag_waddr : m_wnext;
    m_wbus  = jtag_waddr;
    m_wnext = jtag_flags[2] ? a + 32'd4 : a;
    m_mem[a] = jtag_wdata;
    m_wr_cnt++;
    exp_q.push_back('{1'b1, a, jtag_wdata});
  endtask

  task automatic expect_read(input logic force_en, input logic [31:0] fdata);
    logic [31:0] a, d;
    a = (jtag_raddr != m_rbus || !jtag_flags[2]) ? jtag_raddr : m_rnext;
    m_rbus  = jtag_raddr;
    m_rnext = jtag_flags[2] ? a + 32'd4 : a;
    if (force_en) begin
      d = fdata;
      forced_q.push_back(fdata);
    end else begin
      d = m_mem.exists(a) ? m_mem[a] : default_word(a);
    end
    m_last_rd = d;
    m_rd_cnt++;
    exp_q.push_back('{1'b0, a, d});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (SS + 3) @(negedge clk);
    while ((busy || status_out[1]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: still busy=%b pending=%b, required idle", name, busy, status_out[1]);
    end
    @(negedge clk);
  endtask

  // Memory responder: random acknowledge latency, simple RAM behind it
  initial begin : responder
    int dly;
    mem_ack = 1'b0;
    mem_rdata = '0;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        late_ack  = 1'b0;
      end else if (mem_req && !hold_ack) begin
        if (dly == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            s_mem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else if (forced_q.size() > 0) begin
            mem_rdata = forced_q.pop_front();
          end else begin
            mem_rdata = s_mem.exists(mem_addr) ? s_mem[mem_addr] : default_word(mem_addr);
          end
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: every acknowledged request is matched against the scoreboard
  initial begin : monitor
    exp_t        e;
    logic        rd_chk;
    logic [31:0] rd_exp;
    rd_chk = 1'b0;
    rd_exp = '0;
    forever begin
      @(negedge clk);
      if (rd_chk) begin
        chk("rdata_out", rdata_out, rd_exp);
        rd_chk = 1'b0;
      end
      if (!reset && mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: addr %h we %b, required no request", mem_addr, mem_we);
        end else begin
          e = exp_q.pop_front();
          chk("req_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("req_addr", mem_addr, e.addr);
          if (e.we) chk("req_wdata", mem_wdata, e.data);
          else begin
            rd_chk = 1'b1;
            rd_exp = e.data;
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : stim
    int n, gap, kind;
    reset = 1'b1;
    jtag_flags = '0; jtag_raddr = '0; jtag_waddr = '0; jtag_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_status", status_out, 32'd0);
    chk("reset_rdata", rdata_out, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);

    // Single write with latency check
    jtag_waddr = 32'h100; jtag_wdata = 32'hA5A5_0001; jtag_flags[2] = 1'b0;
    expect_write();
    jtag_flags[0] = ~jtag_flags[0];
    repeat (SS + 1) @(negedge clk);
    chk("latency_early", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    chk("latency_req", {31'b0, mem_req}, 32'd1);
    wait_idle("single_write");
    chk("single_wr_count", {24'b0, status_out[31:24]}, 32'd1);
    chk("single_busy", {31'b0, busy}, 32'd0);

    // Auto-increment read burst
    jtag_raddr = 32'h200; jtag_flags[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_read(1'b1, 32'h11 * (i + 1));
      jtag_flags[1] = ~jtag_flags[1];
      wait_idle("burst");
    end
    chk("burst_rdata", rdata_out, 32'h44);
    chk("burst_rd_count", {24'b0, status_out[23:16]}, 32'd4);

    // Simultaneous write and read: write first, one idle cycle between
    jtag_flags[2] = 1'b0;
    jtag_waddr = 32'h300; jtag_raddr = 32'h300; jtag_wdata = $urandom;
    expect_write();
    expect_read(1'b0, 32'h0);
    jtag_flags[1:0] = ~jtag_flags[1:0];
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    chk("simul_first_we", {31'b0, mem_we}, 32'd1);
    while (mem_req && n < 100) begin @(negedge clk); n++; end
    gap = 0;
    while (!mem_req && n < 100) begin gap++; @(negedge clk); n++; end
    chk("simul_gap", gap, 32'd1);
    chk("simul_second_we", {31'b0, mem_we}, 32'd0);
    wait_idle("simul");

    // Overrun: second write toggle while the first is still unacknowledged
    hold_ack = 1'b1;
    jtag_waddr = 32'h400; jtag_wdata = 32'h0BAD_F00D;
    expect_write();
    jtag_flags[0] = ~jtag_flags[0];
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    jtag_flags[0] = ~jtag_flags[0];
    repeat (SS + 3) @(negedge clk);
    chk("overrun_error", {31'b0, status_out[2]}, 32'd1);
    chk("overrun_req_held", {31'b0, mem_req}, 32'd1);
    hold_ack = 1'b0;
    wait_idle("overrun");
    chk("overrun_wr_count", {24'b0, status_out[31:24]}, {24'b0, m_wr_cnt});
    chk("overrun_error_sticky", {31'b0, status_out[2]}, 32'd1);
    jtag_flags[3] = 1'b1;
    repeat (SS + 2) @(negedge clk);
    jtag_flags[3] = 1'b0;
    @(negedge clk);
    chk("error_cleared", {31'b0, status_out[2]}, 32'd0);

    // Reset while a read waits for its acknowledge
    hold_ack = 1'b1;
    jtag_raddr = 32'h500;
    expect_read(1'b0, 32'h0);
    jtag_flags[1] = ~jtag_flags[1];
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    chk("rst_req_before", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    jtag_flags[1:0] = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_dropped", {31'b0, mem_req}, 32'd0);
    chk("rst_status", status_out, 32'd0);
    exp_q.delete();
    model_reset();
    late_ack = 1'b1;
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_late_rdata", rdata_out, 32'd0);
    chk("rst_idle", {31'b0, busy}, 32'd0);

    // Randomized command mix over a small address window
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      jtag_flags[2] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) jtag_waddr = 32'h1000 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 1) == 1) jtag_raddr = 32'h1000 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      jtag_wdata = $urandom;
      if (kind != 1) expect_write();
      if (kind != 0) expect_read(1'b0, 32'h0);
      if (kind != 1) jtag_flags[0] = ~jtag_flags[0];
      if (kind != 0) jtag_flags[1] = ~jtag_flags[1];
      wait_idle("random");
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_wr_count", {24'b0, status_out[31:24]}, {24'b0, m_wr_cnt});
    chk("final_rd_count", {24'b0, status_out[23:16]}, {24'b0, m_rd_cnt});
    chk("final_rdata", rdata_out, m_last_rd);
    chk("final_error", {31'b0, status_out[2]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
